// File: rtl/ping_pong_feature_mem_pkg.sv
// Shared constants and types for the ping-pong feature-map store between
// the maxpool and squeeze 1x1 stages.
package ping_pong_feature_mem_pkg;

    localparam int DW           = 16;
    localparam int CH_IN        = 64;
    localparam int CH_OUT       = 16;
    localparam int SLICES       = CH_IN / CH_OUT;
    localparam int FRAME_PIXELS = 55 * 55;

    typedef logic [DW-1:0] feature_t;

endpackage

// File: rtl/ping_pong_feature_mem_feature_bank.sv
// One feature bank: whole-pixel write port and registered whole-pixel read
// port, written so it maps onto block RAM.
module feature_bank
#(
    parameter int WIDTH = 1024,
    parameter int DEPTH = 4096,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately never reset so the array stays a plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ping_pong_feature_mem.sv
// Double-buffered feature store: pixels go into the write bank, 16-channel
// slices come out of the other bank; the roles swap after each full frame.
module ping_pong_feature_mem
    import ping_pong_feature_mem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        inputsize,
    input  logic                 wren,
    input  logic                 rden,
    input  logic [AW-1:0]        address1,
    input  logic [AW-1:0]        address2,
    input  logic [DW*CH_IN-1:0]  datain,
    output logic [DW*CH_OUT-1:0] dataout
);

    localparam int IW  = $clog2(DEPTH);
    localparam int PW  = DW * CH_IN;
    localparam int SW  = DW * CH_OUT;
    localparam int SLW = $clog2(SLICES);

    logic           wr_sel_q,  wr_sel_d;
    logic           rd_bank_q, rd_bank_d;
    logic [SLW-1:0] slice_q,   slice_d;
    logic           zero_q,    zero_d;

    logic [AW-3:0] rd_pix;
    logic          wr_ok;
    logic          rd_ok;
    logic          swap;

    logic [PW-1:0] bank_rdata [2];
    logic [PW-1:0] rd_word;
    logic [SW-1:0] slice_words [SLICES];

    assign rd_pix = address2[AW-1:2];
    assign wr_ok  = address1 < AW'(DEPTH);
    assign rd_ok  = rd_pix < (AW-2)'(DEPTH);
    // The last pixel of a frame still lands in the current bank; the swap only
    // affects which bank the next edge uses.
    assign swap   = wren && (inputsize != '0) && (address1 == inputsize - AW'(1));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            feature_bank #(
                .WIDTH (PW),
                .DEPTH (DEPTH),
                .IW    (IW)
            ) u_bank (
                .clk   (clk),
                .we    (wren && wr_ok && (wr_sel_q == 1'(gi))),
                .waddr (address1[IW-1:0]),
                .wdata (datain),
                .re    (rden && rd_ok && (wr_sel_q != 1'(gi))),
                .raddr (rd_pix[IW-1:0]),
                .rdata (bank_rdata[gi])
            );
        end

        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            assign slice_words[gi] = rd_word[gi*SW +: SW];
        end
    endgenerate

    // Bank and slice are captured alongside the RAM read so the output mux
    // lines up with the registered bank data one cycle later.
    always_comb begin
        wr_sel_d  = wr_sel_q ^ swap;
        rd_bank_d = rd_bank_q;
        slice_d   = slice_q;
        zero_d    = zero_q;
        if (rden) begin
            rd_bank_d = ~wr_sel_q;
            slice_d   = address2[SLW-1:0];
            zero_d    = ~rd_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel_q  <= 1'b0;
            rd_bank_q <= 1'b1;
            slice_q   <= '0;
            zero_q    <= 1'b1;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_bank_q <= rd_bank_d;
            slice_q   <= slice_d;
            zero_q    <= zero_d;
        end
    end

    assign rd_word = bank_rdata[rd_bank_q];
    assign dataout = zero_q ? '0 : slice_words[slice_q];

endmodule

// File: tb/tb_ping_pong_feature_mem.sv
// Randomized bench for ping_pong_feature_mem against a frame-level model of
// two banks, a write-bank selector and a held read result.
module tb_ping_pong_feature_mem;
    import ping_pong_feature_mem_pkg::*;

    localparam int DEPTH = 4096;
    localparam int AW    = 32;
    localparam int NPIX  = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [AW-1:0]        inputsize = '0;
    logic                 wren = 1'b0;
    logic                 rden = 1'b0;
    logic [AW-1:0]        address1 = '0;
    logic [AW-1:0]        address2 = '0;
    logic [DW*CH_IN-1:0]  datain = '0;
    logic [DW*CH_OUT-1:0] dataout;

    ping_pong_feature_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .inputsize (inputsize),
        .wren      (wren),
        .rden      (rden),
        .address1  (address1),
        .address2  (address2),
        .datain    (datain),
        .dataout   (dataout)
    );

    always #5 clk = ~clk;

    logic [1023:0] mem_m   [2][NPIX];
    bit            known_m [2][NPIX];
    logic [255:0]  exp_m;
    bit            exp_known;
    bit            ws_m;
    int            total = 0;
    int            bad   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [1023:0] pix_word(input int p, input int off);
        logic [1023:0] r;
        feature_t      w;
        r = '0;
        for (int c = 0; c < CH_IN; c++) begin
            w = feature_t'(p * 256 + c + off);
            r[c*DW +: DW] = w;
        end
        return r;
    endfunction

    function automatic logic [1023:0] rand_word();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_state(input string tag);
        if (exp_known) check({tag, "_dout"}, dataout, exp_m);
        check({tag, "_wrsel"}, {255'b0, dut.wr_sel_q}, {255'b0, ws_m});
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, compare just after it.
    task automatic cyc(input string tag, input bit we, input int unsigned a1,
                       input logic [1023:0] din, input bit re, input int unsigned a2);
        int unsigned pix;
        @(negedge clk);
        wren = we; address1 = a1; datain = din; rden = re; address2 = a2;
        @(posedge clk);
        if (re) begin
            pix = a2 >> 2;
            if (pix >= DEPTH) begin
                exp_m = '0; exp_known = 1'b1;
            end else if (pix < NPIX && known_m[!ws_m][pix]) begin
                exp_m = mem_m[!ws_m][pix][(a2 % 4) * 256 +: 256];
                exp_known = 1'b1;
            end else begin
                exp_known = 1'b0;
            end
        end
        if (we && a1 < NPIX) begin
            mem_m[ws_m][a1]   = din;
            known_m[ws_m][a1] = 1'b1;
        end
        if (we && inputsize != 0 && a1 == inputsize - 1) ws_m = !ws_m;
        #1;
        $display("cyc %s we=%0d a1=%0d re=%0d a2=%0d ws=%0d dout=%h", tag, we, a1, re, a2, ws_m, dataout[31:0]);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        wren = 1'b0; rden = 1'b1; address2 = '0;
        rst = 1'b1;
        #1;
        ws_m = 1'b0; exp_m = '0; exp_known = 1'b1;
        check({tag, "_async"}, dataout, 256'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            $display("rst %s ws=%0d dout=%h", tag, ws_m, dataout[31:0]);
            check_state(tag);
        end
        @(negedge clk);
        rst = 1'b0;
        rden = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int p = 0; p < NPIX; p++) known_m[b][p] = 1'b0;
        ws_m = 1'b0; exp_m = '0; exp_known = 1'b1;

        do_reset("reset");
        inputsize = 4;

        // Frame A into bank 0; reads of bank 1 return unwritten data (unchecked).
        for (int p = 0; p < 4; p++) cyc("frameA", 1'b1, p, pix_word(p, 0), 1'b1, 5);
        cyc("rd_p1s1", 1'b0, 0, '0, 1'b1, 5);
        cyc("hold", 1'b0, 0, '0, 1'b0, 15);
        cyc("rd_p3s3", 1'b0, 0, '0, 1'b1, 15);

        // Frame B into bank 1 while bank 0 keeps being read.
        for (int p = 0; p < 4; p++)
            cyc("frameB", 1'b1, p, pix_word(p, 16'h8000), 1'b1, $urandom_range(15, 0));
        cyc("rd_newbank", 1'b0, 0, '0, 1'b1, 0);

        // Out-of-range write and read.
        cyc("wr_oob", 1'b1, DEPTH, rand_word(), 1'b1, DEPTH * 4);
        cyc("rd_oob", 1'b0, 0, '0, 1'b1, DEPTH * 4 + 3);
        cyc("rd_after_oob", 1'b0, 0, '0, 1'b1, 1);

        // Mid-frame reset, then a fresh frame.
        cyc("partial", 1'b1, 0, rand_word(), 1'b0, 0);
        cyc("partial", 1'b1, 1, rand_word(), 1'b0, 0);
        do_reset("midreset");
        for (int p = 0; p < 4; p++) cyc("fresh", 1'b1, p, rand_word(), 1'b1, $urandom_range(15, 0));
        cyc("rd_fresh", 1'b0, 0, '0, 1'b1, 6);

        // Random traffic, including a stretch with inputsize == 0.
        for (int i = 0; i < 400; i++) begin
            bit          we, re;
            int unsigned a1, a2;
            if (i == 150) inputsize = 0;
            if (i == 220) inputsize = 4;
            we = ($urandom_range(1, 0) == 1);
            re = ($urandom_range(9, 0) < 6);
            a1 = ($urandom_range(7, 0) == 0) ? DEPTH + $urandom_range(2, 0) : $urandom_range(3, 0);
            a2 = ($urandom_range(7, 0) == 0) ? (DEPTH + $urandom_range(2, 0)) * 4 + $urandom_range(3, 0)
                                             : $urandom_range(15, 0);
            cyc("rand", we, a1, rand_word(), re, a2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ping_pong_feature_mem.md
Name: ping_pong_feature_mem

Overview:
- Double-buffered feature-map store between the maxpool stage and the squeeze 1x1 stage.
- The producer writes one 64-channel pixel per cycle into the write bank.
- The consumer reads 16-channel slices from the other bank.
- The banks swap roles each time a full frame of `inputsize` pixels has been written.

Parameters:
- DW, 16, bits per channel value (fixed-point).
- CH_IN, 64, channels per written pixel.
- CH_OUT, 16, channels per read slice; CH_IN/CH_OUT = 4 slices per pixel.
- DEPTH, 4096, pixels per bank; must be >= 55*55 = 3025.
- AW, 32, address and size width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- inputsize  in  AW  pixels per frame; sets the bank swap point.
- wren  in  1  write enable for the current write bank.
- rden  in  1  read enable for the current read bank.
- address1  in  AW  write pixel index, 0..inputsize-1.
- address2  in  AW  read word address; [1:0] = slice, [AW-1:2] = pixel index.
- datain  in  DW*CH_IN  pixel; channel c at bits [c*DW +: DW].
- dataout  out  DW*CH_OUT  slice; channel k at bits [k*DW +: DW], equal to pixel channel slice*16+k.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is asynchronous and active-high.
- Reset:
  - wr_sel = 0, so the write bank is bank 0 and the read bank is bank 1.
  - dataout = 0.
  - Memory contents are not cleared.
- Write: on a rising edge with wren=1 and address1 < DEPTH, store datain at bank[wr_sel][address1]. Writes with address1 >= DEPTH are ignored.
- Swap:
  - On an edge with wren=1 and address1 == inputsize-1 (inputsize != 0), the write completes into the current bank, then wr_sel toggles.
  - The just-filled bank becomes the read bank from the next cycle.
  - inputsize == 0 never swaps.
- Read:
  - On an edge with rden=1, dataout <= slice address2[1:0] of bank[~wr_sel][address2>>2].
  - Latency is one cycle (registered).
  - If the pixel index >= DEPTH, dataout <= 0.
  - With rden=0, dataout holds its value.
- Simultaneous read and swap on the same edge: the read uses the pre-swap wr_sel (old read bank).
- Simultaneous write and read of the same pixel: no hazard, since they target different banks.
- Reset mid-frame: wr_sel returns to 0, the partial frame is abandoned and dataout clears. Old memory data remains readable.
- No flow control: the consumer must not run ahead of frame completion. There is no full/empty flag.

Decomposition:
- Shared package holds:
  - constants DW, CH_IN, CH_OUT, SLICES = CH_IN/CH_OUT, and the frame size 55*55;
  - a typedef for the 16-bit feature word.
- One sub-module, feature_bank: a single-port-write, single-port-registered-read array of DEPTH x DW*CH_IN, instantiated twice.
- Top level holds wr_sel, the bank muxes and the slice select.

Test Plan:
- Reset with rden=1, address2=0 → dataout=0 on every cycle while rst=1; wr_sel=0.
- inputsize=4: write pixels 0..3 with channel c of pixel p = p*256+c. Then rden with address2=5 (pixel 1, slice 1) → one cycle later channels 0..15 = 0x0110..0x011F.
- Same frame, address2=15 (pixel 3, slice 3) → channel 0 = 0x0330, channel 15 = 0x033F. Reads issued before the 4th write return bank-1 data, not the new frame.
- Second frame of 4 pixels written with value p*256+c+0x8000 while bank 0 is read continuously → bank-0 reads stay unchanged until the last write. After the swap, address2=0 → 0x8000..0x800F.
- Write at address1=DEPTH and read at pixel DEPTH → the write is ignored (no bank corruption, no swap) and the read returns dataout=0.
- Assert rst mid-frame after 2 of 4 writes → wr_sel=0 and dataout=0. A fresh 4-pixel frame then swaps exactly after its 4th write.
